// File: rtl/mac_filter_pkg.sv
// Shared types and helpers for the destination-MAC stream filter.
package mac_filter_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam mac_addr_t MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {S_HDR, S_REPLAY, S_PASS, S_DROP} mf_state_t;

  // Group address: I/G bit (byte0 bit0) set, excluding the all-ones broadcast.
  function automatic logic is_mcast(input mac_addr_t mac);
    return mac[0] && (mac != MAC_BCAST);
  endfunction

endpackage

// File: rtl/mac_addr_cam.sv
// Programmable unicast address table with a combinational match output.
module mac_addr_cam
  import mac_filter_pkg::*;
#(
  parameter int N_ADDR = 4,
  parameter int IDX_W  = (N_ADDR > 1) ? $clog2(N_ADDR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  mac_addr_t        i_mac,
  input  logic             i_vld,
  input  mac_addr_t        i_key,
  output logic             o_hit
);

  mac_addr_t         r_mac [N_ADDR];
  logic [N_ADDR-1:0] r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (i_we && (int'(i_idx) < N_ADDR)) begin
      r_mac[i_idx] <= i_mac;
      r_vld[i_idx] <= i_vld;
    end
  end

  // Matches against registered contents only, so a same-cycle write is not visible.
  always_comb begin
    o_hit = 1'b0;
    for (int unsigned i = 0; i < N_ADDR; i++) begin
      if (r_vld[i] && (r_mac[i] == i_key)) o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/mac_filter_multi.sv
// AXI-Stream destination-MAC filter: buffers the header, decides, then replays or drops.
// Optional frame counters are enabled with `define MAC_FILTER_STATS_EN.
module mac_filter_multi
  import mac_filter_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int N_ADDR = 4,
  localparam int KEEP_W = DATA_W / 8,
  localparam int IDX_W  = (N_ADDR > 1) ? $clog2(N_ADDR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic              in_tlast,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic              out_tlast,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  mac_addr_t         cfg_mac,
  input  logic              cfg_entry_vld,
  input  logic              cfg_promisc,
  input  logic              cfg_accept_bcast,
  input  logic              cfg_accept_mcast,
  output logic [31:0]       stat_pass_cnt,
  output logic [31:0]       stat_drop_cnt
);

  localparam int         HDR_BEATS = (DATA_W == 32) ? 2 : 1;
  localparam logic [0:0] LAST_HDR  = 1'(HDR_BEATS - 1);

  mf_state_t         r_state, w_state_nxt;
  logic [0:0]        r_hcnt, r_rcnt;
  logic [DATA_W-1:0] r_hdr_data [HDR_BEATS];
  logic [KEEP_W-1:0] r_hdr_keep [HDR_BEATS];
  mac_addr_t         w_key;
  logic              w_hit, w_accept, w_hdr_fire, w_final_hdr;

  // The key combines earlier buffered beats with the beat being accepted now.
  if (HDR_BEATS == 2) begin : g_key2
    assign w_key = {in_tdata[15:0], r_hdr_data[0]};
  end else begin : g_key1
    assign w_key = in_tdata[47:0];
  end

  mac_addr_cam #(.N_ADDR(N_ADDR), .IDX_W(IDX_W)) u_cam (
    .clk   (clk),
    .rst   (rst),
    .i_we  (cfg_we),
    .i_idx (cfg_idx),
    .i_mac (cfg_mac),
    .i_vld (cfg_entry_vld),
    .i_key (w_key),
    .o_hit (w_hit)
  );

  assign w_hdr_fire  = (r_state == S_HDR) && in_tvalid;
  assign w_final_hdr = (r_hcnt == LAST_HDR);
  assign w_accept    = cfg_promisc
                     || ((w_key == MAC_BCAST) && cfg_accept_bcast)
                     || (is_mcast(w_key) && cfg_accept_mcast)
                     || w_hit;

  always_comb begin
    w_state_nxt = r_state;
    in_tready   = 1'b1;
    out_tvalid  = 1'b0;
    out_tdata   = r_hdr_data[r_rcnt];
    out_tkeep   = r_hdr_keep[r_rcnt];
    out_tlast   = 1'b0;
    unique case (r_state)
      S_HDR: begin
        if (w_hdr_fire && w_final_hdr && !in_tlast)
          w_state_nxt = w_accept ? S_REPLAY : S_DROP;
      end
      S_REPLAY: begin
        in_tready  = 1'b0;
        out_tvalid = 1'b1;
        if (out_tready && (r_rcnt == LAST_HDR)) w_state_nxt = S_PASS;
      end
      S_PASS: begin
        out_tvalid = in_tvalid;
        in_tready  = out_tready;
        out_tdata  = in_tdata;
        out_tkeep  = in_tkeep;
        out_tlast  = in_tlast;
        if (in_tvalid && out_tready && in_tlast) w_state_nxt = S_HDR;
      end
      S_DROP: begin
        if (in_tvalid && in_tlast) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HDR;
      r_hcnt  <= '0;
      r_rcnt  <= '0;
      for (int unsigned i = 0; i < HDR_BEATS; i++) begin
        r_hdr_data[i] <= '0;
        r_hdr_keep[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_hdr_fire) begin
        r_hdr_data[r_hcnt] <= in_tdata;
        r_hdr_keep[r_hcnt] <= in_tkeep;
        r_hcnt             <= (in_tlast || w_final_hdr) ? '0 : r_hcnt + 1'b1;
      end
      if ((r_state == S_REPLAY) && out_tready)
        r_rcnt <= (r_rcnt == LAST_HDR) ? '0 : r_rcnt + 1'b1;
    end
  end

`ifdef MAC_FILTER_STATS_EN
  logic        w_decide;
  logic [31:0] r_pass_cnt, r_drop_cnt;

  // Runts (tlast inside the header) end the decision early and always count as drops.
  assign w_decide = w_hdr_fire && (w_final_hdr || in_tlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (w_decide) begin
      if (w_accept && !in_tlast) begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 32'd1;
      end else begin
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign stat_pass_cnt = r_pass_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`else
  assign stat_pass_cnt = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_filter_multi.sv
// Self-checking bench for mac_filter_multi (DATA_W=32): vector table, corner sequences, random frames.
module tb_mac_filter_multi;
  import mac_filter_pkg::*;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int NA = 4;
  localparam int HB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_tvalid = 1'b0, in_tready;
  logic [DW-1:0] in_tdata = '0;
  logic [KW-1:0] in_tkeep = '0;
  logic          in_tlast = 1'b0;
  logic          out_tvalid, out_tready;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic          out_tlast;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  mac_addr_t     cfg_mac = '0;
  logic          cfg_entry_vld = 1'b0;
  logic          cfg_promisc = 1'b0, cfg_accept_bcast = 1'b0, cfg_accept_mcast = 1'b0;
  logic [31:0]   stat_pass_cnt, stat_drop_cnt;

  mac_filter_multi #(.DATA_W(DW), .N_ADDR(NA)) dut (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mac(cfg_mac), .cfg_entry_vld(cfg_entry_vld),
    .cfg_promisc(cfg_promisc), .cfg_accept_bcast(cfg_accept_bcast),
    .cfg_accept_mcast(cfg_accept_mcast),
    .stat_pass_cnt(stat_pass_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    string     nm;
    mac_addr_t mac;
    bit        p, b, m;
    int        len;
    bit        pass;
  } vec_t;

  beat_t     rx[$];
  beat_t     fb[$];
  int        n_chk = 0, n_pass = 0;
  mac_addr_t tm[NA];
  bit        tv[NA];
  int        exp_pc = 0, exp_dc = 0;
  bit        bp_en = 0;

  function automatic mac_addr_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5);
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference decision straight from the filter rules.
  function automatic bit model_pass(input mac_addr_t mac, input int len);
    if (len <= HB) return 0;
    if (cfg_promisc) return 1;
    if (mac == 48'hFFFF_FFFF_FFFF) return cfg_accept_bcast;
    if (mac[0] && cfg_accept_mcast) return 1;
    for (int i = 0; i < NA; i++) if (tv[i] && tm[i] == mac) return 1;
    return 0;
  endfunction

  // Monitor: capture handshakes and check that stalled output holds steady.
  beat_t prev_o;
  bit    prev_hold = 0;
  always @(negedge clk) begin
    if (prev_hold && !rst)
      chk("out_hold", {26'd0, out_tvalid, out_tlast, out_tkeep, out_tdata}, {26'd0, 1'b1, prev_o});
    if (out_tvalid && out_tready) rx.push_back({out_tlast, out_tkeep, out_tdata});
    prev_hold = out_tvalid && !out_tready && !rst;
    prev_o    = {out_tlast, out_tkeep, out_tdata};
  end

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_beat(input beat_t b);
    bit acc;
    int guard;
    in_tvalid = 1'b1; in_tdata = b.d; in_tkeep = b.k; in_tlast = b.l;
    acc = 0; guard = 0;
    while (!acc && guard < 500) begin
      @(negedge clk); acc = in_tready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic build_frame(input mac_addr_t mac, input int len);
    fb.delete();
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = $urandom;
      b.k = 4'($urandom_range(1, 15));
      b.l = (i == len - 1);
      if (i == 0) b.d = mac[31:0];
      else if (i == 1) b.d[15:0] = mac[47:32];
      fb.push_back(b);
    end
  endtask

  task automatic cfg_write(input int idx, input mac_addr_t m, input bit v);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_mac = m; cfg_entry_vld = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tm[idx] = m; tv[idx] = v;
  endtask

  task automatic check_stats(input string nm);
`ifdef MAC_FILTER_STATS_EN
    chk({nm, "_pass_cnt"}, 64'(stat_pass_cnt), 64'(exp_pc));
    chk({nm, "_drop_cnt"}, 64'(stat_drop_cnt), 64'(exp_dc));
`else
    chk({nm, "_pass_cnt"}, 64'(stat_pass_cnt), 64'd0);
    chk({nm, "_drop_cnt"}, 64'(stat_drop_cnt), 64'd0);
`endif
  endtask

  task automatic compare_frame(input string nm, input bit exp_pass);
    int n_exp;
    if (exp_pass) exp_pc++; else exp_dc++;
    n_exp = exp_pass ? fb.size() : 0;
    chk({nm, "_beats"}, 64'(rx.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < rx.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), 64'(rx[i]), 64'(fb[i]));
    check_stats(nm);
  endtask

  task automatic run_frame(input string nm, input mac_addr_t mac, input int len, input bit exp_pass);
    rx.delete();
    build_frame(mac, len);
    foreach (fb[i]) drive_beat(fb[i]);
    @(posedge clk); #1;
    compare_frame(nm, exp_pass);
  endtask

  function automatic mac_addr_t pick_mac();
    mac_addr_t m;
    case ($urandom_range(0, 3))
      0: m = tm[$urandom_range(0, NA - 1)];
      1: m = MAC_BCAST;
      2: m = mk(8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'($urandom_range(0, 255)));
      default: begin
        m = {16'($urandom), 32'($urandom)};
        m[0] = 1'b0;
      end
    endcase
    return m;
  endfunction

  initial begin
    vec_t      vt[13];
    mac_addr_t mac_a, mac_u, mac_m, mac_c, mac_d, mac_e, m;
    int        len;
    bit        rnd_pass;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t      vt[13];
    mac_addr_t mac_a, mac_u, mac_m, mac_c, mac_d, mac_e, m;
    int        len;

    for (int i = 0; i < NA; i++) begin tm[i] = '0; tv[i] = 0; end
    mac_a = mk(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    mac_u = mk(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99);
    mac_m = mk(8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'h01);
    mac_c = mk(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0);
    mac_d = mk(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);
    mac_e = mk(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_in_tready",  64'(in_tready),  64'd1);
    chk("rst_out_tdata",  64'(out_tdata),  64'd0);
    chk("rst_out_tkeep",  64'(out_tkeep),  64'd0);
    chk("rst_out_tlast",  64'(out_tlast),  64'd0);
    check_stats("rst");

    cfg_write(0, mac_a, 1);
    cfg_write(1, mac_d, 0);
    cfg_write(3, mac_e, 1);

    vt[0]  = '{"ucast_hit",     mac_a,     0, 0, 0, 4, 1};
    vt[1]  = '{"ucast_miss",    mac_u,     0, 0, 0, 4, 0};
    vt[2]  = '{"bcast_off",     MAC_BCAST, 0, 0, 0, 4, 0};
    vt[3]  = '{"bcast_on",      MAC_BCAST, 0, 1, 0, 4, 1};
    vt[4]  = '{"mcast_on",      mac_m,     0, 0, 1, 5, 1};
    vt[5]  = '{"mcast_off",     mac_m,     0, 1, 0, 5, 0};
    vt[6]  = '{"promisc",       mac_u,     1, 0, 0, 6, 1};
    vt[7]  = '{"runt1",         mac_a,     1, 1, 1, 1, 0};
    vt[8]  = '{"runt2",         mac_a,     1, 1, 1, 2, 0};
    vt[9]  = '{"min_frame",     mac_a,     0, 0, 0, 3, 1};
    vt[10] = '{"bcast_not_mc",  MAC_BCAST, 0, 0, 1, 4, 0};
    vt[11] = '{"invalid_entry", mac_d,     0, 0, 0, 4, 0};
    vt[12] = '{"entry3_hit",    mac_e,     0, 0, 0, 7, 1};

    foreach (vt[i]) begin
      cfg_promisc = vt[i].p; cfg_accept_bcast = vt[i].b; cfg_accept_mcast = vt[i].m;
      run_frame(vt[i].nm, vt[i].mac, vt[i].len, vt[i].pass);
    end
    cfg_promisc = 0; cfg_accept_bcast = 0; cfg_accept_mcast = 0;

    // Table write on the decision cycle must not affect that decision.
    rx.delete();
    build_frame(mac_c, 4);
    drive_beat(fb[0]);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_mac = mac_c; cfg_entry_vld = 1'b1;
    drive_beat(fb[1]);
    cfg_we = 1'b0;
    tm[2] = mac_c; tv[2] = 1;
    drive_beat(fb[2]);
    drive_beat(fb[3]);
    @(posedge clk); #1;
    compare_frame("cfg_same_cycle", 0);
    run_frame("cfg_next_frame", mac_c, 4, 1);

    // Sixteen-beat accepted frame under random backpressure.
    bp_en = 1;
    run_frame("bp16", mac_a, 16, 1);
    bp_en = 0;
    repeat (2) @(posedge clk);
    #1;

    // First egress beat latency, then reset in the middle of the frame.
    rx.delete();
    build_frame(mac_a, 6);
    drive_beat(fb[0]);
    drive_beat(fb[1]);
    chk("latency_valid", 64'(out_tvalid), 64'd1);
    chk("latency_data",  64'(out_tdata),  64'(fb[0].d));
    drive_beat(fb[2]);
    in_tvalid = 1'b1; in_tdata = fb[3].d; in_tkeep = fb[3].k; in_tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("midrst_in_tready",  64'(in_tready),  64'd1);
    in_tvalid = 1'b0; rst = 1'b0;
    for (int i = 0; i < NA; i++) tv[i] = 0;
    exp_pc = 0; exp_dc = 0;
    check_stats("midrst");
    run_frame("post_rst_ucast", mac_a, 4, 0);
    cfg_accept_bcast = 1;
    run_frame("post_rst_bcast", MAC_BCAST, 5, 1);

    // Random frames against the reference decision.
    bp_en = 1;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, NA - 1), pick_mac(), 1'($urandom_range(0, 3) != 0));
      cfg_promisc      = ($urandom_range(0, 7) == 0);
      cfg_accept_bcast = 1'($urandom_range(0, 1));
      cfg_accept_mcast = 1'($urandom_range(0, 1));
      m   = pick_mac();
      len = $urandom_range(1, 10);
      run_frame($sformatf("rnd%0d", f), m, len, model_pass(m, len));
    end
    bp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
